// File: rtl/sipo_frame_32_if.sv
// rtl/sipo_frame_32_if.sv - serial-in / 32-bit word-out handshake bundle for sipo_frame_32
interface sipo_frame_32_if;
  logic        start;
  logic        ser_in;
  logic        ser_valid;
  logic        word_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        busy;
  logic [5:0]  bit_cnt;
  logic        overrun;
  logic        par_err;

  modport master (
    output start, ser_in, ser_valid, word_ready,
    input  word_out, word_valid, busy, bit_cnt, overrun, par_err
  );

  modport slave (
    input  start, ser_in, ser_valid, word_ready,
    output word_out, word_valid, busy, bit_cnt, overrun, par_err
  );
endinterface

// File: rtl/sipo_frame_32.sv
// rtl/sipo_frame_32.sv - 32-bit serial-to-parallel framer with held output word
// Optional even-parity check after the 32 data bits is enabled by SIPO_PARITY_EN.
module sipo_frame_32 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            n_reset,
  sipo_frame_32_if.slave  bus
);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ovr_q, ovr_d;
  logic        busy_q;
  logic [31:0] shifted;
`ifdef SIPO_PARITY_EN
  logic        perr_q, perr_d;
`endif

  assign shifted = MSB_FIRST ? {shift_q[30:0], bus.ser_in} : {bus.ser_in, shift_q[31:1]};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
`ifdef SIPO_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        // A bit arriving with start is dropped but still flagged.
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = 6'd0;
          shift_d = 32'h0;
          ovr_d   = bus.ser_valid;
        end else if (bus.ser_valid) begin
          ovr_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.ser_valid) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
`ifdef SIPO_PARITY_EN
            state_d = PAR;
`else
            state_d = HOLD;
            word_d  = shifted;
            valid_d = 1'b1;
`endif
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PAR: begin
        if (bus.ser_valid) begin
          state_d = HOLD;
          word_d  = shift_q;
          valid_d = 1'b1;
          perr_d  = (^shift_q) ^ bus.ser_in;
        end
      end
`endif
      HOLD: begin
        if (bus.ser_valid) begin
          ovr_d = 1'b1;
        end
        if (bus.word_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
`ifdef SIPO_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      shift_q <= 32'h0;
      word_q  <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= 6'd0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != IDLE);
`ifdef SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = ovr_q;
`ifdef SIPO_PARITY_EN
  assign bus.par_err    = perr_q;
`else
  assign bus.par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_32.sv
// tb/tb_sipo_frame_32.sv - directed/random bench for sipo_frame_32, MSB-first and LSB-first instances
module tb_sipo_frame_32;
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  sipo_frame_32_if bm();
  sipo_frame_32_if bl();

  sipo_frame_32 #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .n_reset(n_reset), .bus(bm));
  sipo_frame_32 #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .n_reset(n_reset), .bus(bl));

  int checks = 0;
  int errors = 0;
  logic bits_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sd, input logic sv, input logic rdy);
    bm.start = st; bm.ser_in = sd; bm.ser_valid = sv; bm.word_ready = rdy;
    bl.start = st; bl.ser_in = sd; bl.ser_valid = sv; bl.word_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word the stream should assemble into: first bit at [31] or at [0].
  function automatic logic [31:0] exp_word(input bit msb);
    logic [31:0] r;
    r = 32'h0;
    foreach (bits_q[i]) begin
      if (msb) r[31-i] = bits_q[i];
      else     r[i]    = bits_q[i];
    end
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_word_m"}, bm.word_out, 32'h0);
    chk({tag, "_word_l"}, bl.word_out, 32'h0);
    chk({tag, "_valid"}, {31'h0, bm.word_valid}, 32'h0);
    chk({tag, "_busy"}, {31'h0, bm.busy}, 32'h0);
    chk({tag, "_cnt"}, {26'h0, bm.bit_cnt}, 32'h0);
    chk({tag, "_ovr"}, {31'h0, bm.overrun}, 32'h0);
    chk({tag, "_perr"}, {31'h0, bm.par_err}, 32'h0);
    chk({tag, "_busy_l"}, {31'h0, bl.busy}, 32'h0);
  endtask

  task automatic start_frame();
    drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
    chk("start_busy", {31'h0, bm.busy}, 32'h1);
    chk("start_cnt", {26'h0, bm.bit_cnt}, 32'h0);
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits, input int gap, input logic par_flip);
    bits_q.delete();
    for (int i = 0; i < nbits; i++) begin
      bits_q.push_back(w[31-i]);
      drive(0, w[31-i], 1, 0); tick(); drive(0, 0, 0, 0);
      chk("bit_cnt", {26'h0, bm.bit_cnt}, i + 1);
      chk("valid_edge", {31'h0, bm.word_valid}, {31'h0, (i == 31) && !PAR_EN});
      if (i < nbits - 1) repeat (gap) tick();
    end
    if (PAR_EN && nbits == 32) begin
      drive(0, (^w) ^ par_flip, 1, 0); tick(); drive(0, 0, 0, 0);
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_word_m"}, bm.word_out, exp_word(1'b1));
    chk({tag, "_word_l"}, bl.word_out, exp_word(1'b0));
    chk({tag, "_valid"}, {31'h0, bm.word_valid & bl.word_valid}, 32'h1);
    chk({tag, "_cnt"}, {26'h0, bm.bit_cnt}, 32'd32);
    chk({tag, "_busy"}, {31'h0, bm.busy}, 32'h1);
  endtask

  task automatic accept(input string tag);
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    chk({tag, "_valid0"}, {31'h0, bm.word_valid | bl.word_valid}, 32'h0);
    chk({tag, "_busy0"}, {31'h0, bm.busy}, 32'h0);
    chk({tag, "_kept"}, bm.word_out, exp_word(1'b1));
    chk({tag, "_perr0"}, {31'h0, bm.par_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    n_reset = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) tick();
    check_reset("reset");
    n_reset = 1'b1;
    tick();

    start_frame();
    send_frame(32'hA5A5_0F0F, 32, 0, 0);
    check_frame("fixed");
    chk("fixed_const_m", bm.word_out, 32'hA5A5_0F0F);
    chk("fixed_const_l", bl.word_out, 32'hF0F0_A5A5);
    accept("fixed");

    // Gapped frame held for five cycles with overrun and an ignored start.
    w = $urandom;
    start_frame();
    send_frame(w, 32, 3, 0);
    check_frame("gap");
    drive(0, 1, 1, 0); tick(); drive(0, 0, 0, 0);
    chk("hold_ovr", {31'h0, bm.overrun}, 32'h1);
    chk("hold_ovr_word", bm.word_out, exp_word(1'b1));
    chk("hold_ovr_cnt", {26'h0, bm.bit_cnt}, 32'd32);
    drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
    check_frame("hold_start");
    repeat (3) begin
      tick();
      check_frame("hold_wait");
    end
    accept("gap");
    chk("idle_ovr_sticky", {31'h0, bm.overrun}, 32'h1);
    start_frame();
    chk("start_clears_ovr", {31'h0, bm.overrun}, 32'h0);

    // Asynchronous reset mid-frame, applied between clock edges.
    send_frame($urandom, 17, 1, 0);
    #2 n_reset = 1'b0;
    #1 check_reset("async");
    tick();
    n_reset = 1'b1;

    drive(1, 1, 1, 0); tick(); drive(0, 0, 0, 0);
    chk("start_bit_ovr", {31'h0, bm.overrun}, 32'h1);
    chk("start_bit_busy", {31'h0, bm.busy}, 32'h1);
    chk("start_bit_cnt", {26'h0, bm.bit_cnt}, 32'h0);
    send_frame($urandom, 32, 0, 0);
    check_frame("post_reset");
    accept("post_reset");

    for (int k = 0; k < 3; k++) begin
      start_frame();
      send_frame($urandom, 32, $urandom_range(0, 2), 0);
      check_frame("rand");
      accept("rand");
    end

    start_frame();
    send_frame(32'h0000_0001, 32, 0, 0);
    check_frame("par_good");
    chk("par_good_err", {31'h0, bm.par_err}, 32'h0);
    accept("par_good");
    start_frame();
    send_frame(32'h0000_0001, 32, 0, 1);
    check_frame("par_bad");
    chk("par_bad_err", {31'h0, bm.par_err}, {31'h0, PAR_EN});
    accept("par_bad");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_frame_32.md
SIPO_FRAME_32 -- requirements
Module: sipo_frame_32

Interface
REQ-001 Parameter MSB_FIRST, default 1: 1 = first received bit lands in word_out[31]; 0 = first received bit lands in word_out[0].
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a new 32-bit frame.
REQ-005 The block SHALL have port ser_in, input, 1 bit: serial data bit.
REQ-006 The block SHALL have port ser_valid, input, 1 bit: ser_in is valid this cycle.
REQ-007 The block SHALL have port word_ready, input, 1 bit: the downstream 32-bit register accepts word_out.
REQ-008 The block SHALL have port word_out, output, 32 bits: assembled word, which feeds the downstream register's data input.
REQ-009 The block SHALL have port word_valid, output, 1 bit: word_out holds a complete, unaccepted frame.
REQ-010 The block SHALL have port busy, output, 1 bit: the block is not in IDLE.
REQ-011 The block SHALL have port bit_cnt, output, 6 bits: data bits received in the current frame (0..32).
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag, set when serial data arrives while the block cannot take it.
REQ-013 The block SHALL have port par_err, output, 1 bit: parity mismatch on the held frame.

Function
REQ-014 The block SHALL implement states IDLE, SHIFT, PAR and HOLD; all outputs SHALL be registered.
REQ-015 IDLE SHALL move to SHIFT on start=1, clear bit_cnt and the shift register, and clear overrun.
REQ-016 In SHIFT, each cycle with ser_valid=1 SHALL shift ser_in in (MSB_FIRST order) and increment bit_cnt; cycles with ser_valid=0 SHALL hold all state.
REQ-017 On the ser_valid cycle that brings bit_cnt to 32, the block SHALL enter HOLD (or PAR, per REQ-026) with no gap cycle.
REQ-018 On entry to HOLD, word_out SHALL load the full 32-bit word, and word_valid SHALL go 1 in the cycle after the 32nd bit is sampled.
REQ-019 In HOLD, word_valid SHALL stay 1 and word_out SHALL stay stable until word_ready=1 is sampled; the block SHALL then return to IDLE, with word_valid 0 in the next cycle.
REQ-020 word_out SHALL keep the last completed word after acceptance, and SHALL change only on completion of a new frame.
REQ-021 start while in SHIFT, PAR or HOLD SHALL be ignored.
REQ-022 ser_valid=1 while in IDLE or HOLD SHALL set overrun and SHALL leave word_out and bit_cnt unchanged.
REQ-023 If start=1 and ser_valid=1 in the same IDLE cycle, start SHALL take effect and the bit SHALL be discarded, setting overrun.
REQ-024 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-025 On n_reset=0 the block SHALL, immediately and independently of clk, force: state IDLE, word_out 32'h0000_0000, word_valid 0, busy 0, bit_cnt 0, overrun 0, par_err 0; a reset mid-frame SHALL discard the partial frame.

Configuration
REQ-026 Macro SIPO_PARITY_EN, when defined: after bit 32 the block SHALL enter PAR; the next ser_valid bit is an even-parity bit over the 32 data bits; the block SHALL then enter HOLD with par_err = 1 when the parity fails, and par_err SHALL clear on leaving HOLD.
REQ-027 When SIPO_PARITY_EN is undefined, the PAR state SHALL be absent, the block SHALL go from SHIFT to HOLD directly, and par_err SHALL be constant 0.

Verification
REQ-028 Reset, start, then 32 ser_valid bits of 32'hA5A5_0F0F MSB first -> word_out = 32'hA5A5_0F0F, word_valid = 1 one cycle after the last bit, bit_cnt = 32.
REQ-029 With MSB_FIRST=0, the same bit stream -> word_out = bit-reversed value 32'hF0F0_A5A5.
REQ-030 Frame sent with ser_valid gaps of 3 cycles; word_ready held 0 for 5 cycles, then 1 -> word_out stable throughout; word_valid falls the cycle after word_ready; busy = 0.
REQ-031 ser_valid=1 while in HOLD -> overrun = 1, word_out unchanged; next start -> overrun = 0.
REQ-032 Assert n_reset=0 after 17 bits -> all outputs go to reset values asynchronously; a new frame then completes correctly.
REQ-033 With SIPO_PARITY_EN defined: word 32'h0000_0001 with parity bit 1 -> par_err = 0; with parity bit 0 -> par_err = 1 while word_valid = 1.
